// File: rtl/transaction_sequencer.sv
// -----------------------------------------------------------------------------
// transaction_sequencer
//
// Walks a single transaction through NUM_STEPS ordered steps (for example
// process, hash, store). Each step finishes when its done_step bit is seen, or
// on its first cycle if its AUTO_DONE_MASK bit is set. Steps named in the skip
// mask latched at start are bypassed at no cycle cost. An optional per-step
// watchdog moves the sequencer to ERROR and records the step that stalled.
// abort returns to IDLE from any state.
//
// Ports
//   clock       in   1          system clock, rising edge
//   resetn      in   1          asynchronous active-low reset
//   start       in   1          level; accepted only in IDLE
//   abort       in   1          level; returns to IDLE from any state
//   skip_mask   in   NUM_STEPS  bit k-1 set: step k bypassed (latched on start)
//   done_step   in   NUM_STEPS  bit k-1: step k complete (used only while step==k)
//   step        out  STEP_W     current step code, 0 when not running
//   busy        out  1          high while running
//   finished    out  1          one-cycle pulse when a transaction completes
//   error       out  1          high while in ERROR
//   error_step  out  STEP_W     step that timed out, valid while error is high
// -----------------------------------------------------------------------------
module transaction_sequencer #(
    parameter int                   NUM_STEPS      = 4,
    parameter int                   STEP_W         = 3,
    parameter int                   TIMEOUT_W      = 16,
    parameter int                   TIMEOUT        = 50000,
    parameter logic [NUM_STEPS-1:0] AUTO_DONE_MASK = 4'b0100
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_STEPS-1:0] skip_mask,
    input  logic [NUM_STEPS-1:0] done_step,
    output logic [STEP_W-1:0]    step,
    output logic                 busy,
    output logic                 finished,
    output logic                 error,
    output logic [STEP_W-1:0]    error_step
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic WDOG_EN = (TIMEOUT != 0) ? 1'b1 : 1'b0;

    state_t                 state_r;
    logic [STEP_W-1:0]      step_r;
    logic                   busy_r;
    logic                   finished_r;
    logic                   error_r;
    logic [STEP_W-1:0]      error_step_r;
    logic [TIMEOUT_W-1:0]   count_r;
    logic [NUM_STEPS-1:0]   skip_r;

    logic [NUM_STEPS-1:0]   step_sel_s;
    logic                   done_k_s;
    logic                   timeout_hit_s;
    logic [STEP_W-1:0]      first_step_s;
    logic [STEP_W-1:0]      next_step_s;

    // Lowest step code above cur that is not masked off; 0 when none remain.
    // Scanning downward lets the lowest qualifying step overwrite the result last.
    function automatic logic [STEP_W-1:0] next_unskipped(
        input logic [STEP_W-1:0]    cur,
        input logic [NUM_STEPS-1:0] mask
    );
        logic [STEP_W-1:0] res;
        res = {STEP_W{1'b0}};
        for (int j = NUM_STEPS; j >= 1; j--) begin
            if ((j > int'(cur)) && !mask[j-1]) begin
                res = STEP_W'(j);
            end
        end
        return res;
    endfunction

    // One-hot decode of the current step so only that step's done bit is seen.
    always_comb begin
        step_sel_s = {NUM_STEPS{1'b0}};
        for (int k = 1; k <= NUM_STEPS; k++) begin
            step_sel_s[k-1] = (step_r == STEP_W'(k));
        end
    end

    // Completion, watchdog expiry and step-successor lookups for this cycle.
    always_comb begin
        done_k_s      = |((done_step | AUTO_DONE_MASK) & step_sel_s);
        timeout_hit_s = WDOG_EN && (count_r == TIMEOUT_W'(TIMEOUT - 1));
        first_step_s  = next_unskipped({STEP_W{1'b0}}, skip_mask);
        next_step_s   = next_unskipped(step_r, skip_r);
    end

    // Sequencer state machine with registered outputs; abort outranks all else.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            step_r       <= {STEP_W{1'b0}};
            busy_r       <= 1'b0;
            finished_r   <= 1'b0;
            error_r      <= 1'b0;
            error_step_r <= {STEP_W{1'b0}};
            count_r      <= {TIMEOUT_W{1'b0}};
            skip_r       <= {NUM_STEPS{1'b0}};
        end else if (abort) begin
            state_r      <= ST_IDLE;
            step_r       <= {STEP_W{1'b0}};
            busy_r       <= 1'b0;
            finished_r   <= 1'b0;
            error_r      <= 1'b0;
            error_step_r <= {STEP_W{1'b0}};
            count_r      <= {TIMEOUT_W{1'b0}};
        end else begin
            finished_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        skip_r  <= skip_mask;
                        count_r <= {TIMEOUT_W{1'b0}};
                        if (first_step_s == {STEP_W{1'b0}}) begin
                            // Every step bypassed: complete without running.
                            finished_r <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            step_r  <= first_step_s;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Done is tested first so it beats a simultaneous timeout.
                    if (done_k_s) begin
                        count_r <= {TIMEOUT_W{1'b0}};
                        if (next_step_s == {STEP_W{1'b0}}) begin
                            state_r    <= ST_IDLE;
                            step_r     <= {STEP_W{1'b0}};
                            busy_r     <= 1'b0;
                            finished_r <= 1'b1;
                        end else begin
                            step_r <= next_step_s;
                        end
                    end else if (timeout_hit_s) begin
                        state_r      <= ST_ERROR;
                        error_r      <= 1'b1;
                        error_step_r <= step_r;
                        step_r       <= {STEP_W{1'b0}};
                        busy_r       <= 1'b0;
                        count_r      <= {TIMEOUT_W{1'b0}};
                    end else begin
                        count_r <= count_r + TIMEOUT_W'(1);
                    end
                end
                ST_ERROR: begin
                    // Parked until abort or reset; start has no effect here.
                    error_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    step_r  <= {STEP_W{1'b0}};
                    busy_r  <= 1'b0;
                    error_r <= 1'b0;
                    count_r <= {TIMEOUT_W{1'b0}};
                end
            endcase
        end
    end

    assign step       = step_r;
    assign busy       = busy_r;
    assign finished   = finished_r;
    assign error      = error_r;
    assign error_step = error_step_r;

endmodule

// File: tb/tb_transaction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_transaction_sequencer
//
// Directed scenarios followed by randomized traffic, all compared each cycle
// against a behavioural model of the sequencing rules (mode, step number,
// per-step wait counter, latched skip set).
// -----------------------------------------------------------------------------
module tb_transaction_sequencer;

    localparam int         NS   = 4;
    localparam int         SW   = 3;
    localparam int         TO   = 8;
    localparam logic [3:0] AUTO = 4'b0100;

    logic          clock;
    logic          resetn;
    logic          start;
    logic          abort;
    logic [NS-1:0] skip_mask;
    logic [NS-1:0] done_step;
    logic [SW-1:0] step;
    logic          busy;
    logic          finished;
    logic          error;
    logic [SW-1:0] error_step;

    int checks;
    int errors;
    int fin_count;

    // Model: mode 0 idle, 1 running, 2 error.
    int m_mode;
    int m_step;
    int m_cnt;
    int m_mask;
    int m_fin;
    int m_estep;

    transaction_sequencer #(
        .NUM_STEPS      (NS),
        .STEP_W         (SW),
        .TIMEOUT_W      (16),
        .TIMEOUT        (TO),
        .AUTO_DONE_MASK (AUTO)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .skip_mask  (skip_mask),
        .done_step  (done_step),
        .step       (step),
        .busy       (busy),
        .finished   (finished),
        .error      (error),
        .error_step (error_step)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // First step number after k whose bit in mask is clear; 0 if none.
    function automatic int first_after(input int k, input int mask);
        for (int j = k + 1; j <= NS; j++) begin
            if (((mask >> (j - 1)) & 1) == 0) return j;
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_step  = 0;
        m_cnt   = 0;
        m_mask  = 0;
        m_fin   = 0;
        m_estep = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        if (abort) begin
            m_mode = 0;
            m_step = 0;
            m_cnt  = 0;
            m_fin  = 0;
        end else begin
            m_fin = 0;
            if (m_mode == 0) begin
                if (start) begin
                    m_mask = int'(skip_mask);
                    m_cnt  = 0;
                    m_step = first_after(0, m_mask);
                    if (m_step == 0) m_fin = 1;
                    else m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if ((done_step[m_step-1] | AUTO[m_step-1]) == 1'b1) begin
                    m_cnt  = 0;
                    m_step = first_after(m_step, m_mask);
                    if (m_step == 0) begin
                        m_mode = 0;
                        m_fin  = 1;
                    end
                end else if (m_cnt == TO - 1) begin
                    m_mode  = 2;
                    m_estep = m_step;
                    m_step  = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("step", 32'(step), m_step);
        check("busy", 32'(busy), (m_mode == 1) ? 1 : 0);
        check("finished", 32'(finished), m_fin);
        check("error", 32'(error), (m_mode == 2) ? 1 : 0);
        if (m_mode == 2) check("error_step", 32'(error_step), m_estep);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check_outputs();
        if (finished === 1'b1) fin_count++;
    endtask

    int dseq  [8] = '{0, 1, 0, 2, 0, 0, 0, 8};
    int estep [8] = '{1, 1, 2, 2, 3, 4, 4, 4};

    initial begin
        checks    = 0;
        errors    = 0;
        fin_count = 0;
        resetn    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        skip_mask = 4'b0000;
        done_step = 4'b0000;
        model_reset();

        // Reset state
        #2;
        check_outputs();
        check("rst_error_step", 32'(error_step), 0);
        @(negedge clock);
        resetn = 1'b1;
        tick();

        // Test 1: full walk with step 3 auto-completing
        fin_count = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t1_seq", 32'(step), estep[i]);
            done_step = 4'(dseq[i]);
            tick();
        end
        done_step = 4'b0000;
        check("t1_end_step", 32'(step), 0);
        tick();
        check("t1_fin_once", fin_count, 1);

        // Test 2: skip steps 2 and 4
        skip_mask = 4'b1010;
        done_step = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_s1", 32'(step), 1);
        tick();
        check("t2_s3", 32'(step), 3);
        tick();
        check("t2_fin", 32'(finished), 1);
        done_step = 4'b0000;
        tick();

        // Test 3: everything skipped
        skip_mask = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_step", 32'(step), 0);
        check("t3_fin", 32'(finished), 1);
        tick();

        // Test 4: watchdog timeout, start ignored, abort clears
        skip_mask = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("t4_no_err_yet", 32'(error), 0);
        tick();
        check("t4_err", 32'(error), 1);
        check("t4_err_step", 32'(error_step), 1);
        start = 1'b1;
        tick();
        check("t4_start_ignored", 32'(busy), 0);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort", 32'(error), 0);
        tick();

        // Test 5: done on the last permitted cycle wins over timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        done_step = 4'b0001;
        tick();
        done_step = 4'b0000;
        check("t5_step2", 32'(step), 2);
        check("t5_no_err", 32'(error), 0);
        for (int i = 0; i < 7; i++) tick();
        check("t5_count_restart", 32'(error), 0);

        // Test 6a: abort during step 2
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6a_step", 32'(step), 0);
        check("t6a_nofin", 32'(finished), 0);

        // Test 6b: async reset during step 3
        start = 1'b1;
        tick();
        start = 1'b0;
        done_step = 4'b0001;
        tick();
        done_step = 4'b0010;
        tick();
        done_step = 4'b0000;
        check("t6b_at3", 32'(step), 3);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        resetn = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6b_restart", 32'(step), 1);
        done_step = 4'b1111;
        for (int i = 0; i < 5; i++) tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 31) == 0);
            skip_mask = 4'($urandom);
            done_step = 4'($urandom & $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
